mmio_periph_hub: RTL

- Parametrised memory-mapped IO hub between the single-cycle CPU's load/store path and the board peripherals: LED bank, switch bank, confirm button and multiplexed seven-segment display.
- Replaces the separate io/button/leds/seg_ctrl chain with one register-mapped block.
- Adds:
  - switch and button debouncing;
  - a sticky confirm flag with write-1-to-clear;
  - configurable digit count, scan rate and per-digit enable mask.

---
 rtl/mmio_periph_hub.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_periph_hub.sv
// MMIO hub for the CPU load/store path: LED bank, debounced switches and confirm button, scanned seven-segment display.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.

module mmio_periph_hub_deb #(
   parameter int DEB_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   input  logic acc_i,
   output logic acc_d_o
);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cnt_end;

   assign cnt_end = (cnt_q == CW'(DEB_CYCLES - 1));

   // The accepted value itself lives in the parent so edge detection can see acc_d/acc_q together.
   always_comb begin
      cnt_d   = '0;
      acc_d_o = acc_i;
      if (sync2_q != acc_i) begin
         if (cnt_end) acc_d_o = sync2_q;
         else         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end
endmodule

module mmio_periph_hub #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFFFC00,
   parameter int          LED_W      = 24,
   parameter int          SW_W       = 16,
   parameter int          SEG_DIGITS = 8,
   parameter int          SCAN_DIV   = 50000,
   parameter int          DEB_CYCLES = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           io_addr,
   input  logic [31:0]           io_wdata,
   input  logic                  io_wen,
   input  logic                  io_ren,
   output logic [31:0]           io_rdata,
   input  logic [SW_W-1:0]       sw_in,
   input  logic                  btn_confirm,
   output logic [LED_W-1:0]      led_out,
   output logic [SEG_DIGITS-1:0] seg_an,
   output logic [7:0]            seg_cat
);
   localparam int SEG_BITS = 4 * SEG_DIGITS;
   localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W    = (SEG_DIGITS > 1) ? $clog2(SEG_DIGITS) : 1;

   logic                  hit, wr_en;
   logic [2:0]            reg_sel;
   logic [LED_W-1:0]      led_q, led_d;
   logic [SEG_BITS-1:0]   seg_q, seg_d;
   logic [SEG_DIGITS-1:0] mask_q, mask_d;
   logic                  pend_q, pend_d;
   logic [SW_W:0]         raw_in, deb_q, deb_d;
   logic                  btn_rise;
   logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
   logic [DIG_W-1:0]      dig_q, dig_d;
   logic                  scan_tc;
   logic [3:0]            nib;
   logic [SEG_DIGITS-1:0] blank, an_q, an_d;
   logic [7:0]            cat_q, cat_d;

   assign hit     = (io_addr[31:5] == BASE_ADDR[31:5]) && (io_addr[1:0] == 2'b00);
   assign reg_sel = io_addr[4:2];
   assign wr_en   = io_wen & hit;

   // Top bit of the debounce vector is the confirm button, the rest are switches.
   assign raw_in = {btn_confirm, sw_in};
   for (genvar g = 0; g <= SW_W; g++) begin : g_deb
      mmio_periph_hub_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk    (clk),
         .rst    (rst),
         .raw_i  (raw_in[g]),
         .acc_i  (deb_q[g]),
         .acc_d_o(deb_d[g])
      );
   end
   assign btn_rise = deb_d[SW_W] & ~deb_q[SW_W];

   always_comb begin
      led_d  = led_q;
      seg_d  = seg_q;
      mask_d = mask_q;
      pend_d = pend_q;
      if (wr_en) begin
         case (reg_sel)
            3'd0:    led_d  = io_wdata[LED_W-1:0];
            3'd2:    seg_d  = io_wdata[SEG_BITS-1:0];
            3'd3:    if (io_wdata[0]) pend_d = 1'b0;
            3'd4:    mask_d = io_wdata[SEG_DIGITS-1:0];
            default: ;
         endcase
      end
      // A new press overrides a clear landing in the same cycle.
      if (btn_rise) pend_d = 1'b1;
   end

   always_comb begin
      io_rdata = '0;
      if (io_ren && hit) begin
         case (reg_sel)
            3'd0:    io_rdata = 32'(led_q);
            3'd1:    io_rdata = 32'(deb_q[SW_W-1:0]);
            3'd2:    io_rdata = 32'(seg_q);
            3'd3:    io_rdata = {30'd0, deb_q[SW_W], pend_q};
            3'd4:    io_rdata = 32'(mask_q);
            default: io_rdata = '0;
         endcase
      end
   end

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'hC0;
         4'h1: hex7 = 8'hF9;
         4'h2: hex7 = 8'hA4;
         4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;
         4'h5: hex7 = 8'h92;
         4'h6: hex7 = 8'h82;
         4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;
         4'h9: hex7 = 8'h90;
         4'hA: hex7 = 8'h88;
         4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;
         4'hD: hex7 = 8'hA1;
         4'hE: hex7 = 8'h86;
         default: hex7 = 8'h8E;
      endcase
   endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // Walk down from the top digit; masked digits do not break a run of leading zeros.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      blank      = '0;
      for (int i = SEG_DIGITS - 1; i > 0; i--) begin
         if (mask_q[i]) zero_above = zero_above & (seg_q[4*i +: 4] == 4'h0);
         blank[i] = zero_above;
      end
   end
`else
   assign blank = '0;
`endif

   assign scan_tc = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
   assign nib     = seg_q[{dig_q, 2'b00} +: 4];

   always_comb begin
      scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;
      dig_d      = dig_q;
      if (scan_tc) dig_d = (dig_q == DIG_W'(SEG_DIGITS - 1)) ? '0 : dig_q + 1'b1;
      an_d  = '1;
      cat_d = 8'hFF;
      if (mask_q[dig_q]) begin
         an_d = ~(SEG_DIGITS'(1) << dig_q);
         if (!blank[dig_q]) cat_d = hex7(nib);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q      <= '0;
         seg_q      <= '0;
         mask_q     <= '1;
         pend_q     <= 1'b0;
         deb_q      <= '0;
         scan_cnt_q <= '0;
         dig_q      <= '0;
         an_q       <= '1;
         cat_q      <= 8'hFF;
      end else begin
         led_q      <= led_d;
         seg_q      <= seg_d;
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         deb_q      <= deb_d;
         scan_cnt_q <= scan_cnt_d;
         dig_q      <= dig_d;
         an_q       <= an_d;
         cat_q      <= cat_d;
      end
   end

   assign led_out = led_q;
   assign seg_an  = an_q;
   assign seg_cat = cat_q;
endmodule
